// File: rtl/rs_age_scheduler.sv
// rs_age_scheduler
//   Reservation-station entry manager with an oldest-first issue scheduler
//   for a single functional unit. Dispatch receives the lowest free entry
//   index. An age matrix records the relative order of occupied entries.
//   Each cycle, the oldest woken-up entry is issued, freed and broadcast on
//   clear_lines.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   alloc_req     dispatch wants one entry this cycle
//   alloc_ready   at least one entry free (combinational)
//   alloc_index   lowest-numbered free entry, 0 when full (combinational)
//   ready_vec     per-entry operands-ready from wakeup
//   issue_stall   FU cannot accept an issue this cycle
//   flush         squash all entries
//   issue_valid   registered: an entry issued at the last edge
//   issue_index   registered: index of the issued entry (holds otherwise)
//   clear_lines   registered: one-hot of the issued entry, else 0
//   valid_vec     registered entry-occupied bits
//   occupancy     registered popcount of valid_vec

module rs_age_scheduler #(
    parameter int RS_ENTRIES = 8,
    localparam int IDX_W = $clog2(RS_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_index,
    input  logic [RS_ENTRIES-1:0] ready_vec,
    input  logic                  issue_stall,
    input  logic                  flush,
    output logic                  issue_valid,
    output logic [IDX_W-1:0]      issue_index,
    output logic [RS_ENTRIES-1:0] clear_lines,
    output logic [RS_ENTRIES-1:0] valid_vec,
    output logic [IDX_W:0]        occupancy
);

    // older[i][j] = 1: entry i is older than entry j
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older;

    logic [RS_ENTRIES-1:0] cand;
    logic [RS_ENTRIES-1:0] grant_vec;
    logic [IDX_W-1:0]      grant_idx;
    logic                  alloc_fire;
    logic                  issue_fire;

    assign alloc_ready = ~(&valid_vec);
    assign alloc_fire  = alloc_req & alloc_ready & ~flush;
    assign cand        = valid_vec & ready_vec;
    assign issue_fire  = (|cand) & ~issue_stall & ~flush;

    // Lowest free entry. Scanning downward leaves the lowest hit as the last
    // assignment.
    always_comb begin
        alloc_index = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) alloc_index = IDX_W'(i);
        end
    end

    // An entry is granted when no other candidate is older than it. Because
    // the matrix is a total order over valid entries, at most one bit is set.
    always_comb begin
        grant_vec = '0;
        for (int g = 0; g < RS_ENTRIES; g++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (cand[j] && older[j][g]) blocked = 1'b1;
            end
            grant_vec[g] = cand[g] & ~blocked;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (grant_vec[i]) grant_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_vec   <= '0;
            older       <= '0;
            issue_valid <= 1'b0;
            issue_index <= '0;
            clear_lines <= '0;
            occupancy   <= '0;
        end else if (flush) begin
            // The age matrix is left stale. Allocation rewrites an entry's row
            // and column before that entry becomes valid again.
            valid_vec   <= '0;
            issue_valid <= 1'b0;
            clear_lines <= '0;
            occupancy   <= '0;
        end else begin
            logic [RS_ENTRIES-1:0] valid_nxt;
            valid_nxt = valid_vec;
            if (issue_fire) valid_nxt[grant_idx] = 1'b0;
            if (alloc_fire) valid_nxt[alloc_index] = 1'b1;
            valid_vec <= valid_nxt;

            // The new entry is younger than every entry that was valid
            // before this edge.
            if (alloc_fire) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older[alloc_index][j] <= 1'b0;
                    older[j][alloc_index] <= valid_vec[j];
                end
            end

            if (issue_fire) begin
                issue_valid <= 1'b1;
                issue_index <= grant_idx;
                clear_lines <= grant_vec;
            end else begin
                issue_valid <= 1'b0;
                clear_lines <= '0;
            end

            case ({alloc_fire, issue_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_age_scheduler.sv
module tb_rs_age_scheduler;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_req;
    logic         alloc_ready;
    logic [2:0]   alloc_index;
    logic [N-1:0] ready_vec;
    logic         issue_stall;
    logic         flush;
    logic         issue_valid;
    logic [2:0]   issue_index;
    logic [N-1:0] clear_lines;
    logic [N-1:0] valid_vec;
    logic [3:0]   occupancy;

    int checks = 0;
    int errors = 0;

    rs_age_scheduler #(.RS_ENTRIES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_index (alloc_index),
        .ready_vec   (ready_vec),
        .issue_stall (issue_stall),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_index (issue_index),
        .clear_lines (clear_lines),
        .valid_vec   (valid_vec),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue(input string tag, input logic [2:0] idx);
        check({tag, " issue_valid"}, 32'(issue_valid), 32'd1);
        check({tag, " issue_index"}, 32'(issue_index), 32'(idx));
        check({tag, " clear_lines"}, 32'(clear_lines), 32'(8'd1 << idx));
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        repeat (n) step();
        alloc_req = 1'b0;
    endtask

    // Issue order after entry 3 is re-allocated last
    logic [2:0] order3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};

    initial begin
        rst = 1'b1; alloc_req = 1'b0; ready_vec = '0; issue_stall = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;

        check("rst valid_vec",   32'(valid_vec),   32'h0);
        check("rst occupancy",   32'(occupancy),   32'h0);
        check("rst issue_valid", 32'(issue_valid), 32'h0);
        check("rst issue_index", 32'(issue_index), 32'h0);
        check("rst clear_lines", 32'(clear_lines), 32'h0);
        check("rst alloc_ready", 32'(alloc_ready), 32'h1);

        // Fill: alloc_index walks 0..7
        alloc_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("fill alloc_index %0d", i), 32'(alloc_index), 32'(i));
            step();
        end
        alloc_req = 1'b0;
        check("full alloc_ready", 32'(alloc_ready), 32'h0);
        check("full occupancy",   32'(occupancy),   32'd8);
        check("full valid_vec",   32'(valid_vec),   32'hff);
        check("full alloc_index", 32'(alloc_index), 32'h0);

        // Full: alloc_req ignored
        alloc_req = 1'b1; step(); alloc_req = 1'b0;
        check("full ignore occupancy", 32'(occupancy), 32'd8);

        // Issue entry 3 and re-allocate it as the youngest entry
        ready_vec = 8'h08; step(); ready_vec = '0;
        check_issue("iss3", 3'd3);
        check("iss3 occupancy",   32'(occupancy),   32'd7);
        check("iss3 alloc_ready", 32'(alloc_ready), 32'h1);
        check("iss3 alloc_index", 32'(alloc_index), 32'd3);
        alloc_n(1);
        check("realloc3 valid_vec", 32'(valid_vec), 32'hff);
        check("realloc3 occupancy", 32'(occupancy), 32'd8);

        ready_vec = 8'hff;
        for (int k = 0; k < N; k++) begin
            step();
            check_issue($sformatf("drain %0d", k), order3[k]);
        end
        ready_vec = '0;
        step();
        check("drain idle issue_valid", 32'(issue_valid), 32'h0);
        check("drain idle clear_lines", 32'(clear_lines), 32'h0);
        check("drain idle occupancy",   32'(occupancy),   32'h0);
        check("drain idle issue_index", 32'(issue_index), 32'd3);

        // Three entries issue in age order
        alloc_n(3);
        check("t2 valid_vec", 32'(valid_vec), 32'h07);
        ready_vec = 8'h07;
        step(); check_issue("t2 a", 3'd0);
        step(); check_issue("t2 b", 3'd1);
        step(); check_issue("t2 c", 3'd2);
        ready_vec = '0;
        step();
        check("t2 idle issue_valid", 32'(issue_valid), 32'h0);
        check("t2 hold issue_index", 32'(issue_index), 32'd2);

        // Stall
        alloc_n(2);
        ready_vec = 8'h03; issue_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall %0d issue_valid", k), 32'(issue_valid), 32'h0);
            check($sformatf("stall %0d valid_vec", k),   32'(valid_vec),   32'h03);
        end
        issue_stall = 1'b0;
        step(); check_issue("unstall a", 3'd0);
        step(); check_issue("unstall b", 3'd1);
        ready_vec = '0;
        step();
        check("t4 occupancy", 32'(occupancy), 32'h0);

        // Simultaneous alloc and issue with 5 valid entries
        alloc_n(5);
        alloc_req = 1'b1; ready_vec = 8'h01;
        check("t5 alloc_index", 32'(alloc_index), 32'd5);
        step();
        alloc_req = 1'b0; ready_vec = '0;
        check_issue("t5", 3'd0);
        check("t5 occupancy", 32'(occupancy), 32'd5);
        check("t5 valid_vec", 32'(valid_vec), 32'h3e);
        check("t5 freed alloc_index", 32'(alloc_index), 32'd0);

        // Flush clears out, then 4 valid entries are flushed together with alloc and a ready entry
        flush = 1'b1; step(); flush = 1'b0;
        check("pre-t6 valid_vec", 32'(valid_vec), 32'h0);
        alloc_n(4);
        check("t6 setup occupancy", 32'(occupancy), 32'd4);
        flush = 1'b1; alloc_req = 1'b1; ready_vec = 8'h04;
        step();
        flush = 1'b0; alloc_req = 1'b0; ready_vec = '0;
        check("t6 valid_vec",   32'(valid_vec),   32'h0);
        check("t6 issue_valid", 32'(issue_valid), 32'h0);
        check("t6 clear_lines", 32'(clear_lines), 32'h0);
        check("t6 occupancy",   32'(occupancy),   32'h0);
        check("t6 alloc_ready", 32'(alloc_ready), 32'h1);
        check("t6 issue_index", 32'(issue_index), 32'd0);

        // Age order after flush: entry 2 allocated before entry 0 and 1 reuse
        alloc_n(3);
        ready_vec = 8'h01; step(); ready_vec = '0;
        check_issue("pf0", 3'd0);
        alloc_n(1);
        ready_vec = 8'h07;
        step(); check_issue("pf a", 3'd1);
        step(); check_issue("pf b", 3'd2);
        step(); check_issue("pf c", 3'd0);
        ready_vec = '0;

        // Reset mid-operation also zeros issue_index
        alloc_n(2);
        ready_vec = 8'h02; step(); ready_vec = '0;
        check_issue("mid", 3'd1);
        alloc_req = 1'b1; rst = 1'b1; step(); rst = 1'b0; alloc_req = 1'b0;
        check("midrst valid_vec",   32'(valid_vec),   32'h0);
        check("midrst issue_index", 32'(issue_index), 32'h0);
        check("midrst occupancy",   32'(occupancy),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
